// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with phase offset and tick output.
// Config writes land directly when idle, otherwise at the next period boundary.
module clk_div_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_STOP} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] phase;
    } cfg_t;

    localparam cfg_t CFG_RST = '{div: CNT_W'(2), high: CNT_W'(1), phase: '0};

    function automatic cfg_t clamp_cfg(input logic [CNT_W-1:0] d,
                                       input logic [CNT_W-1:0] h,
                                       input logic [CNT_W-1:0] p);
        cfg_t c;
        c.div   = (d < CNT_W'(2)) ? CNT_W'(2) : d;
        c.high  = h;
        c.phase = (p >= c.div) ? c.div - CNT_W'(1) : p;
        return c;
    endfunction

    cfg_t              w_cfg_new;
    logic [NUM_CH-1:0] w_pend;

    assign w_cfg_new = clamp_cfg(cfg_div, cfg_high, cfg_phase);

    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = ~w_pend[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_st, w_st_n;
        logic [CNT_W-1:0] r_cnt, w_cnt_n;
        cfg_t             r_act, w_act_n;
        cfg_t             r_shd, w_shd_n;
        logic             r_pend, w_pend_n;
        logic             r_clk, r_tick, r_run;
        logic             w_clk_n, w_tick_n, w_xfer, w_apply;

        assign w_xfer    = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));
        assign w_pend[g] = r_pend;

        always_comb begin
            w_st_n   = r_st;
            w_cnt_n  = r_cnt;
            w_act_n  = r_act;
            w_shd_n  = r_shd;
            w_pend_n = r_pend;
            w_apply  = 1'b0;
            w_clk_n  = 1'b0;
            w_tick_n = 1'b0;
            unique case (r_st)
                S_IDLE: begin
                    // a write in the same cycle as en rising feeds that start
                    if (w_xfer) w_act_n = w_cfg_new;
                    w_cnt_n = '0;
                    if (en[g]) begin
                        w_st_n = (w_act_n.phase == '0) ? S_RUN : S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (!en[g]) begin
                        w_st_n  = S_IDLE;
                        w_cnt_n = '0;
                        w_apply = 1'b1;
                    end else if (r_cnt == r_act.phase - CNT_W'(1)) begin
                        w_st_n  = S_RUN;
                        w_cnt_n = '0;
                        w_apply = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
                S_RUN, S_STOP: begin
                    if (r_cnt == r_act.div - CNT_W'(1)) begin
                        w_cnt_n = '0;
                        w_apply = 1'b1;
                        w_st_n  = en[g] ? S_RUN : S_IDLE;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                        w_st_n  = en[g] ? S_RUN : S_STOP;
                    end
                end
            endcase
            if (r_st != S_IDLE) begin
                if (w_apply && r_pend) begin
                    w_act_n  = r_shd;
                    w_pend_n = 1'b0;
                end
                if (w_xfer) begin
                    if (w_st_n == S_IDLE) begin
                        w_act_n = w_cfg_new;
                    end else begin
                        w_shd_n  = w_cfg_new;
                        w_pend_n = 1'b1;
                    end
                end
            end
            if (w_st_n == S_RUN || w_st_n == S_STOP) begin
                w_clk_n  = (w_cnt_n < w_act_n.high);
                w_tick_n = (w_cnt_n == '0);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_st   <= S_IDLE;
                r_cnt  <= '0;
                r_act  <= CFG_RST;
                r_shd  <= CFG_RST;
                r_pend <= 1'b0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
                r_run  <= 1'b0;
            end else begin
                r_st   <= w_st_n;
                r_cnt  <= w_cnt_n;
                r_act  <= w_act_n;
                r_shd  <= w_shd_n;
                r_pend <= w_pend_n;
                r_clk  <= w_clk_n;
                r_tick <= w_tick_n;
                r_run  <= (w_st_n != S_IDLE);
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
        assign running[g] = r_run;
    end

endmodule
